// File: rtl/paula_audio_pkg.sv
// Shared definitions for the Paula audio mixer slice.
//   SAMPLE_W/VOL_W/PROD_W/MIX_W : datapath widths
//   phase_e                      : 4-phase frame sequencer states (PH_CH0..PH_CH3)
//   VOL_FULL                     : full-scale effective volume
//   vol_eff()                    : volume clamp (bit6 set => 64)
package paula_audio_pkg;

   localparam int SAMPLE_W = 8;
   localparam int VOL_W    = 7;
   localparam int PROD_W   = 14;
   localparam int MIX_W    = 15;

   localparam logic [VOL_W-1:0] VOL_FULL = 7'd64;

   // Each phase value is also the index of the channel multiplied in that phase.
   typedef enum logic [1:0] {
      PH_CH0 = 2'd0,
      PH_CH1 = 2'd1,
      PH_CH2 = 2'd2,
      PH_CH3 = 2'd3
   } phase_e;

   // Any volume with bit6 set is full scale; bits 5:0 are then ignored.
   function automatic logic [VOL_W-1:0] vol_eff(input logic [VOL_W-1:0] vol);
      return vol[6] ? VOL_FULL : {1'b0, vol[5:0]};
   endfunction

endpackage

// File: rtl/paula_audio_mixer_if.sv
// Stereo output bus from the mixer to the DAC/filter stage.
//   ldata : left mix, 15-bit two's complement
//   rdata : right mix, 15-bit two's complement
//   valid : one-clk strobe when ldata/rdata update
// master = mixer (drives), slave = DAC/filter (receives).
interface paula_audio_mixer_if;
   import paula_audio_pkg::*;

   logic [MIX_W-1:0] ldata;
   logic [MIX_W-1:0] rdata;
   logic             valid;

   modport master (output ldata, output rdata, output valid);
   modport slave  (input  ldata, input  rdata, input  valid);

endinterface

// File: rtl/paula_audio_volmul.sv
// Combinational volume scaler: clamps the volume and multiplies it with a
// signed sample.
//   sample_i : 8-bit two's complement sample
//   volume_i : 7-bit raw volume (0..64, bit6 set = full scale)
//   prod_o   : 14-bit signed product, range -8192..+8128
module paula_audio_volmul
   import paula_audio_pkg::*;
(
   input  logic [SAMPLE_W-1:0]      sample_i,
   input  logic [VOL_W-1:0]         volume_i,
   output logic signed [PROD_W-1:0] prod_o
);

   logic [VOL_W-1:0]         veff;
   logic signed [PROD_W-1:0] smp_ext;
   logic signed [PROD_W-1:0] vol_ext;

   assign veff = vol_eff(volume_i);

   // Both operands are widened to the product width first so the multiply is
   // performed at 14 bits; the true product always fits, so nothing is lost.
   assign smp_ext = {{(PROD_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
   assign vol_ext = {{(PROD_W-VOL_W){1'b0}}, veff};
   assign prod_o  = smp_ext * vol_ext;

endmodule

// File: rtl/paula_audio_mixer.sv
// Four-channel Paula audio mixer. One shared multiplier is time-multiplexed
// over a 4-phase frame advanced by clk7_en; left = ch0+ch3, right = ch1+ch2.
//   clk, reset        : bus clock, synchronous active-high reset (qualified by clk7_en)
//   clk7_en           : 7 MHz enable; all state advances only when high
//   sample0..sample3  : 8-bit signed channel samples
//   volume0..volume3  : 7-bit channel volumes
//   dac               : output bus (ldata/rdata/valid)
//   SWAP_LR           : 1 exchanges the ldata/rdata outputs
module paula_audio_mixer
   import paula_audio_pkg::*;
#(
   parameter bit SWAP_LR = 1'b0
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                clk7_en,
   input  logic [SAMPLE_W-1:0] sample0,
   input  logic [SAMPLE_W-1:0] sample1,
   input  logic [SAMPLE_W-1:0] sample2,
   input  logic [SAMPLE_W-1:0] sample3,
   input  logic [VOL_W-1:0]    volume0,
   input  logic [VOL_W-1:0]    volume1,
   input  logic [VOL_W-1:0]    volume2,
   input  logic [VOL_W-1:0]    volume3,
   paula_audio_mixer_if.master dac
);

   phase_e phase_q, phase_d;

   // Channel 0 is multiplied from the live inputs in the snapshot phase itself,
   // so only channels 1..3 need hold registers.
   logic [SAMPLE_W-1:0] snap_smp_q [1:3];
   logic [SAMPLE_W-1:0] snap_smp_d [1:3];
   logic [VOL_W-1:0]    snap_vol_q [1:3];
   logic [VOL_W-1:0]    snap_vol_d [1:3];

   logic [MIX_W-1:0] accl_q,  accl_d;
   logic [MIX_W-1:0] accr_q,  accr_d;
   logic [MIX_W-1:0] ldata_q, ldata_d;
   logic [MIX_W-1:0] rdata_q, rdata_d;
   logic             valid_q, valid_d;

   logic [SAMPLE_W-1:0]      mul_smp;
   logic [VOL_W-1:0]         mul_vol;
   logic signed [PROD_W-1:0] prod;
   logic [MIX_W-1:0]         prod_ext;
   logic [MIX_W-1:0]         left_mix;

   // Operand mux for the single multiplier, selected by phase.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      mul_smp = sample0;
      mul_vol = volume0;
      unique case (phase_q)
         PH_CH0: begin mul_smp = sample0;       mul_vol = volume0;       end
         PH_CH1: begin mul_smp = snap_smp_q[1]; mul_vol = snap_vol_q[1]; end
         PH_CH2: begin mul_smp = snap_smp_q[2]; mul_vol = snap_vol_q[2]; end
         PH_CH3: begin mul_smp = snap_smp_q[3]; mul_vol = snap_vol_q[3]; end
      endcase
   end

   paula_audio_volmul u_volmul (
      .sample_i (mul_smp),
      .volume_i (mul_vol),
      .prod_o   (prod)
   );

   assign prod_ext = {prod[PROD_W-1], prod};
   assign left_mix = accl_q + prod_ext;

   // Phase sequencer and datapath next state.
   always_comb begin
      phase_d    = phase_q;
      snap_smp_d = snap_smp_q;
      snap_vol_d = snap_vol_q;
      accl_d     = accl_q;
      accr_d     = accr_q;
      ldata_d    = ldata_q;
      rdata_d    = rdata_q;
      valid_d    = 1'b0;   // strobe drops on the next clk whether or not enabled
      if (clk7_en) begin
         phase_d = phase_e'(phase_q + 2'd1);
         unique case (phase_q)
            PH_CH0: begin
               snap_smp_d[1] = sample1;  snap_vol_d[1] = vol_eff(volume1);
               snap_smp_d[2] = sample2;  snap_vol_d[2] = vol_eff(volume2);
               snap_smp_d[3] = sample3;  snap_vol_d[3] = vol_eff(volume3);
               accl_d        = prod_ext;
               accr_d        = '0;
            end
            PH_CH1: accr_d = prod_ext;
            PH_CH2: accr_d = accr_q + prod_ext;
            PH_CH3: begin
               ldata_d = SWAP_LR ? accr_q   : left_mix;
               rdata_d = SWAP_LR ? left_mix : accr_q;
               valid_d = 1'b1;
            end
         endcase
      end
   end

   // Reset only acts on an enabled edge; with clk7_en low everything holds.
   always_ff @(posedge clk) begin
      if (reset && clk7_en) begin
         phase_q    <= PH_CH0;
         snap_smp_q <= '{default: '0};
         snap_vol_q <= '{default: '0};
         accl_q     <= '0;
         accr_q     <= '0;
         ldata_q    <= '0;
         rdata_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         phase_q    <= phase_d;
         snap_smp_q <= snap_smp_d;
         snap_vol_q <= snap_vol_d;
         accl_q     <= accl_d;
         accr_q     <= accr_d;
         ldata_q    <= ldata_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
      end
   end

   assign dac.ldata = ldata_q;
   assign dac.rdata = rdata_q;
   assign dac.valid = valid_q;

endmodule

// File: tb/tb_paula_audio_mixer.sv
// Directed self-checking bench for paula_audio_mixer. Two instances share the
// stimulus: u_dut (SWAP_LR=0) and u_swp (SWAP_LR=1).
module tb_paula_audio_mixer;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk7_en;
   logic [7:0] smp [4];
   logic [6:0] vol [4];

   int checks = 0;
   int errors = 0;

   paula_audio_mixer_if if_dut ();
   paula_audio_mixer_if if_swp ();

   always #5 clk = ~clk;

   paula_audio_mixer #(.SWAP_LR(1'b0)) u_dut (
      .clk(clk), .reset(reset), .clk7_en(clk7_en),
      .sample0(smp[0]), .sample1(smp[1]), .sample2(smp[2]), .sample3(smp[3]),
      .volume0(vol[0]), .volume1(vol[1]), .volume2(vol[2]), .volume3(vol[3]),
      .dac(if_dut.master)
   );

   paula_audio_mixer #(.SWAP_LR(1'b1)) u_swp (
      .clk(clk), .reset(reset), .clk7_en(clk7_en),
      .sample0(smp[0]), .sample1(smp[1]), .sample2(smp[2]), .sample3(smp[3]),
      .volume0(vol[0]), .volume1(vol[1]), .volume2(vol[2]), .volume3(vol[3]),
      .dac(if_swp.master)
   );

   task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic set_stim(input logic [7:0] s0, s1, s2, s3,
                           input logic [6:0] v0, v1, v2, v3);
      smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
      vol[0] = v0; vol[1] = v1; vol[2] = v2; vol[3] = v3;
   endtask

   // One clk cycle with clk7_en high; returns #1 after the edge with enable low.
   task automatic edge7();
      @(negedge clk);
      clk7_en = 1'b1;
      @(posedge clk);
      #1;
      clk7_en = 1'b0;
   endtask

   // One clk cycle with clk7_en low.
   task automatic idle_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic check_valid(input string tag, input logic exp);
      check({tag, " valid"},     {14'd0, if_dut.valid}, {14'd0, exp});
      check({tag, " valid_swp"}, {14'd0, if_swp.valid}, {14'd0, exp});
   endtask

   task automatic check_out(input string tag, input logic [14:0] exp_l, input logic [14:0] exp_r);
      check({tag, " ldata"},     if_dut.ldata, exp_l);
      check({tag, " rdata"},     if_dut.rdata, exp_r);
      check({tag, " ldata_swp"}, if_swp.ldata, exp_r);
      check({tag, " rdata_swp"}, if_swp.rdata, exp_l);
   endtask

   // Full frame from phase 0: no strobe on the first three enables, strobe and
   // new data on the fourth, strobe gone one clk later.
   task automatic run_frame(input string tag, input logic [14:0] exp_l, input logic [14:0] exp_r);
      for (int i = 0; i < 3; i++) begin
         edge7();
         check_valid({tag, " early"}, 1'b0);
      end
      edge7();
      check_valid({tag, " strobe"}, 1'b1);
      check_out(tag, exp_l, exp_r);
      idle_clk();
      check_valid({tag, " after"}, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      clk7_en = 1'b1;
      set_stim(8'h00, 8'h00, 8'h00, 8'h00, 7'd0, 7'd0, 7'd0, 7'd0);

      // Reset with enable high.
      repeat (2) @(posedge clk);
      #1;
      check_valid("reset", 1'b0);
      check_out("reset", 15'h0000, 15'h0000);
      reset   = 1'b0;
      clk7_en = 1'b0;

      // First strobe exactly on the 4th enable after release.
      run_frame("first", 15'h0000, 15'h0000);

      // 127*64 + (-128)*64 = -64 ; 64*32 + (-1)*1 = 2047
      set_stim(8'h7F, 8'h40, 8'hFF, 8'h80, 7'd64, 7'd32, 7'd1, 7'd64);
      run_frame("mix", 15'h7FC0, 15'h07FF);

      // Volume clamp: 16 * clamp(0x7F)=64 -> 1024.
      set_stim(8'h10, 8'h55, 8'h66, 8'h77, 7'h7F, 7'd0, 7'd0, 7'd0);
      run_frame("clamp_7f", 15'h0400, 15'h0000);
      set_stim(8'h10, 8'h55, 8'h66, 8'h77, 7'h40, 7'd0, 7'd0, 7'd0);
      run_frame("clamp_40", 15'h0400, 15'h0000);
      // ch3: -2 * clamp(0x41)=64 -> -128 ; 1024-128 = 896. ch1: 3*63 = 189.
      set_stim(8'h10, 8'h03, 8'h00, 8'hFE, 7'h40, 7'h3F, 7'd0, 7'h41);
      run_frame("clamp_41", 15'h0380, 15'h00BD);

      // Extremes: -8192*2 = -16384 ; 8128*2 = 16256.
      set_stim(8'h80, 8'h7F, 8'h7F, 8'h80, 7'd64, 7'd64, 7'd64, 7'd64);
      run_frame("extreme", 15'h4000, 15'h3F80);

      // Inputs changed after the snapshot do not affect the current frame.
      set_stim(8'h00, 8'h40, 8'h00, 8'h00, 7'd0, 7'd64, 7'd0, 7'd0);
      edge7();
      check_valid("snap ph0", 1'b0);
      edge7();
      check_valid("snap ph1", 1'b0);
      smp[1] = 8'h00;
      smp[0] = 8'h7F;
      vol[0] = 7'd64;
      // Enable held low for 10 clk: nothing moves.
      for (int i = 0; i < 10; i++) begin
         idle_clk();
         check_valid("hold", 1'b0);
         check("hold ldata", if_dut.ldata, 15'h4000);
      end
      edge7();
      check_valid("snap ph2", 1'b0);
      edge7();
      check_valid("snap strobe", 1'b1);
      check_out("snap", 15'h0000, 15'h1000);
      idle_clk();
      check_valid("snap after", 1'b0);
      run_frame("snap_next", 15'h1FC0, 15'h0000);

      // Reset mid-frame: enable-low reset holds, enabled reset clears and restarts.
      set_stim(8'h7F, 8'h40, 8'hFF, 8'h80, 7'd64, 7'd32, 7'd1, 7'd64);
      edge7();
      edge7();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_out("rst_hold", 15'h1FC0, 15'h0000);
      edge7();
      check_valid("rst_mid", 1'b0);
      check_out("rst_mid", 15'h0000, 15'h0000);
      reset = 1'b0;
      idle_clk();
      check_valid("rst_idle", 1'b0);
      run_frame("after_rst", 15'h7FC0, 15'h07FF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/paula_audio_mixer.md
Name: paula_audio_mixer

Overview:
Downstream consumer of the four Paula audio channels. Each channel presents an 8-bit sample and a 7-bit volume. The block scales every sample by its volume using a single time-multiplexed multiplier, then sums the channels into stereo: left is ch0+ch3, right is ch1+ch2. Once per 4-phase frame it delivers registered signed 15-bit left/right words to the DAC/filter stage, together with a one-cycle valid strobe.

Parameters:
SWAP_LR, 0, when 1 the ldata/rdata outputs are exchanged (channel-to-side mapping unchanged internally).

Ports:
clk  input  1  bus clock
reset  input  1  synchronous, active-high reset
clk7_en  input  1  7 MHz clock enable; all state advances only when high
sample0..sample3  input  8 each  channel samples, two's complement
volume0..volume3  input  7 each  channel volumes, unsigned 0..64 (bit6 set = full scale)
ldata  output  15  left mix, two's complement
rdata  output  15  right mix, two's complement
valid  output  1  high for exactly one clk cycle (coincident with clk7_en) when ldata/rdata update

Behaviour:
- Reset (sync, active-high, checked only when clk7_en=1; reset with clk7_en=0 holds): phase=0, accL=accR=0, snapshot regs=0, ldata=rdata=0, valid=0. Reset wins over any phase activity.
- Effective volume: veff = volume[6] ? 7'd64 : {1'b0,volume[5:0]}. Values 0x41..0x7F clamp to 64.
- Product: signed(sample) * veff. Result is 14-bit signed, range -8192..+8128. Sign-extend to 15 bits before any add.
- Phase counter: 2 bits, increments on every clk7_en and wraps 3->0. With clk7_en=0, every register holds its value.
- Phase 0: snapshot all four samples and effective volumes into hold registers. accL <= prod(ch0), using the live inputs for ch0 (identical to the snapshot value). accR <= 0.
- Phase 1: accR <= prod(ch1 snapshot).
- Phase 2: accR <= accR + prod(ch2 snapshot).
- Phase 3: ldata <= accL + prod(ch3 snapshot). rdata <= accR. Sides are swapped if SWAP_LR=1. valid <= 1.
- valid: asserted on the clk edge following the phase-3 clk7_en. It deasserts on the next clk edge regardless of clk7_en, so the pulse is exactly one clk wide.
- Latency: inputs sampled at the phase-0 edge appear on the outputs after the phase-3 edge, i.e. 3 clk7_en periods later. Output rate is clk7_en/4.
- Arithmetic: the two-channel sum spans -16384..+16256, which always fits 15 bits. No saturation logic; overflow cannot occur.
- Input changes during phases 1-3 have no effect on the current frame; only the snapshot is used.
- Reset asserted mid-frame discards the partial accumulation and restarts at phase 0 with outputs zeroed.
- Exactly one multiplier instance. Its operand mux is selected by phase.

Decomposition:
- Shared package paula_audio_pkg:
  - SAMPLE_W=8, VOL_W=7, PROD_W=14, MIX_W=15
  - phase localparams PH_CH0..PH_CH3 (2'd0..2'd3)
  - VOL_FULL=7'd64
- One sub-module, paula_audio_volmul: combinational volume clamp plus signed 8x7 multiply, 14-bit signed result. The top level holds the phase FSM, snapshot registers, accumulators and output registers.

Test Plan:
- Reset with clk7_en=1 then release -> ldata=rdata=0, valid=0; first valid pulse appears exactly 4 clk7_en edges after release.
- ch0=0x7F/vol 64, ch3=0x80/vol 64, ch1=0x40/vol 32, ch2=0xFF/vol 1 -> ldata=-64 (0x7FC0), rdata=2047 (0x07FF).
- Volume clamp: ch0=0x10/vol 0x7F, all others vol 0 -> ldata=1024, rdata=0. Repeat with vol 0x40 -> identical result.
- Extremes: ch0=ch3=0x80, vol 64 -> ldata=-16384 (0x4000). ch1=ch2=0x7F, vol 64 -> rdata=16256 (0x3F80).
- Change sample1 from 0x40 to 0x00 during phase 2 -> rdata still reflects 0x40 this frame and 0 next frame. Hold clk7_en low for 10 clk -> no state change, valid stays 0.
- SWAP_LR=1 with the stimulus of test 2 -> ldata=2047, rdata=-64. Reset asserted at phase 2 -> outputs 0, phase restarts, no valid pulse for the aborted frame.
